// File: rtl/ring_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the ring counter controller.
package ring_ctrl_pkg;

  typedef enum logic [1:0] {
    OpLoad  = 2'b00,
    OpRotl  = 2'b01,
    OpRotr  = 2'b10,
    OpClear = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/ring_reg.sv
// Ring register: load, clear and single-step rotate left/right.
// Clear has priority over load, load over rotate.
module ring_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             rotl_i,
  input  logic             rotr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d, count_q;

  // Select the next ring value from the one-cycle enables.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = data_i;
    end else if (rotl_i) begin
      count_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    end else if (rotr_i) begin
      count_d = {count_q[0], count_q[WIDTH-1:1]};
    end
  end

  // Ring state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ring_counter_ctrl.sv
// Ring counter controller: accepts LOAD/CLEAR/ROTL/ROTR commands and runs
// multi-step rotations with abort. Optional wrap detection is enabled by
// defining RING_CTRL_WRAP_DETECT_EN.
module ring_counter_ctrl
  import ring_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] RemOne = CNT_W'(1);

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] rem_q;
  logic             busy_q, done_q, ready_q;

  op_e  cmd_op_e;
  logic accept, run_step;
  logic load_en, clear_en, rotl_en, rotr_en;

  // Decode accept and per-edge register enables.
  always_comb begin
    cmd_op_e = op_e'(cmd_op);
    accept   = cmd_valid && ready_q;
    load_en  = accept && (cmd_op_e == OpLoad);
    clear_en = accept && (cmd_op_e == OpClear);
    // abort suppresses the rotation on the edge it is seen.
    run_step = (state_q == StRun) && !abort;
    rotl_en  = run_step && (op_q == OpRotl);
    rotr_en  = run_step && (op_q == OpRotr);
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= OpLoad;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            ready_q <= 1'b0;
            if ((cmd_op_e == OpLoad) || (cmd_op_e == OpClear) || (cmd_count == '0)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              op_q    <= cmd_op_e;
              rem_q   <= cmd_count;
              busy_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (abort || (rem_q == RemOne)) begin
            state_q <= StDone;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            rem_q <= rem_q - RemOne;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          rem_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  ring_reg #(
    .WIDTH(WIDTH)
  ) u_ring_reg (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (load_en),
    .clear_i(clear_en),
    .rotl_i (rotl_en),
    .rotr_i (rotr_en),
    .data_i (cmd_data),
    .count_o(count)
  );

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef RING_CTRL_WRAP_DETECT_EN
  logic [WIDTH-1:0] pat_q, rot_nxt;
  logic             wrap_q;

  // Value the ring takes on this edge if a rotation happens.
  always_comb begin
    rot_nxt = (op_q == OpRotl) ? {count[WIDTH-2:0], count[WIDTH-1]} :
                                 {count[0], count[WIDTH-1:1]};
  end

  // Capture the pattern at accept and flag rotations that return to it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= (rotl_en || rotr_en) && (rot_nxt == pat_q);
      if (accept) begin
        pat_q <= count;
      end
    end
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: doc/ring_counter_ctrl.md
RING_COUNTER_CTRL -- requirements
Module: ring_counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, ring register width.
REQ-002 SHALL have parameter CNT_W, default 4, step-count field width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_op  input  2  00 LOAD, 01 ROTL, 10 ROTR, 11 CLEAR.
REQ-008 SHALL have port cmd_data  input  WIDTH  LOAD value.
REQ-009 SHALL have port cmd_count  input  CNT_W  rotate step count n.
REQ-010 SHALL have port abort  input  1  synchronous stop of a running rotate.
REQ-011 SHALL have port count  output  WIDTH  ring register value.
REQ-012 SHALL have port busy  output  1  high in RUN.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port wrap  output  1  one-cycle pattern-return pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; cmd_ready = 1 only in IDLE.
REQ-016 Accept edge T (cmd_valid & cmd_ready): LOAD sets count=cmd_data, CLEAR sets count=0, both go DONE.
REQ-017 ROTL/ROTR with n>0 SHALL latch op and n, go RUN; count unchanged at T.
REQ-018 ROTL/ROTR with n=0 SHALL go DONE with count unchanged.
REQ-019 In RUN each edge SHALL rotate count by one (ROTL: {count[W-2:0],count[W-1]}; ROTR: {count[0],count[W-1:1]}) and decrement remaining.
REQ-020 Rotations SHALL occur at edges T+1..T+n; the edge performing the n-th rotation SHALL move to DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done=0 otherwise.
REQ-022 abort high in RUN SHALL suppress rotation at that edge and move to DONE; abort outside RUN SHALL be ignored.
REQ-023 abort and cmd_valid in the same IDLE cycle: command accepted, abort ignored.
REQ-024 cmd_valid outside IDLE SHALL be ignored (held by requester until cmd_ready).
REQ-025 Remaining counter SHALL be CNT_W bits; n = 2^CNT_W-1 SHALL execute fully without overflow.

Reset
REQ-026 reset low SHALL immediately force IDLE, count=0, remaining=0, busy=0, done=0, wrap=0, cmd_ready=1 after release.
REQ-027 reset asserted mid-RUN SHALL discard the command; no done pulse follows.

Configuration
REQ-028 With RING_CTRL_WRAP_DETECT_EN defined, the pattern at accept SHALL be captured and wrap SHALL pulse in the cycle after any RUN rotation whose result equals it.
REQ-029 Without RING_CTRL_WRAP_DETECT_EN, wrap SHALL be tied 0 and no capture register SHALL exist.

Structure
REQ-030 Opcode encodings and FSM state enum SHALL live in shared package ring_ctrl_pkg.
REQ-031 The rotate register SHALL be sub-module ring_reg (load, clear, rotl, rotr enables; WIDTH param).

Verification
REQ-032 LOAD 4'b0001 -> count=0001 after T, done=1 in cycle T+1, cmd_ready=1 at T+2.
REQ-033 From 0001, ROTL n=3 -> count 0010, 0100, 1000 after T+1..T+3; busy high 3 cycles; done pulse after T+3.
REQ-034 From 0001, ROTR n=5 -> 1000, 0100, 0010, 0001, 1000; with macro, wrap pulse once after 4th rotation; without, wrap=0.
REQ-035 From 0001, ROTL n=8, abort in 3rd RUN cycle -> final count 0100, single done pulse, no further rotation.
REQ-036 ROTR n=0 -> count unchanged, busy never high, done one cycle after accept.
REQ-037 reset low during RUN of ROTL n=6 -> count=0 immediately, no done, next LOAD accepted normally.
